axis_rx_pkt_checker: RTL and testbench
======================================

AXIS_RX_PKT_CHECKER -- requirements
Module: axis_rx_pkt_checker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512, AXIS tdata width in bits.
REQ-002 SHALL have parameter KEEP_WIDTH, default 64, which SHALL equal DATA_WIDTH/8.
REQ-003 SHALL have parameter USER_WIDTH, default 1, AXIS tuser width.
REQ-004 SHALL have port CLK  input  1  single clock, rising-edge.
REQ-005 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports s_axis_tvalid / tready / tlast / tdata / tkeep / tuser  in/out/in/in/in/in  1/1/1/DATA_WIDTH/KEEP_WIDTH/USER_WIDTH  CMAC RX stream.
REQ-007 SHALL have port enable  input  1  check enable, level.
REQ-008 SHALL have port pkt_size  input  16  expected packet length in bytes, 1..65535, sampled at the enable rising edge.
REQ-009 SHALL have outputs recv_pkt_cnt, err_pkt_cnt, total_beat_cnt, perf_beat_cnt, perf_cycle_cnt  output  32 each  statistics.
REQ-010 SHALL have outputs first_pkt_seen, perf_cycle_full  output  1 each  status flags.

Function
REQ-011 The beat is accepted when s_axis_tvalid && s_axis_tready.
REQ-012 s_axis_tready SHALL be 0 in reset and 1 on every cycle thereafter; the sink never back-pressures.
REQ-013 Beats accepted while enable=0 SHALL be discarded and SHALL NOT change any counter.
REQ-014 The FSM SHALL have states IDLE, RECV and DRAIN.
REQ-015 The transitions SHALL be: IDLE->RECV on the enable rising edge; any state->IDLE when enable=0.
REQ-016 The transitions SHALL be: RECV->DRAIN on a late-tlast error; DRAIN->RECV on an accepted tlast beat.
REQ-017 On the enable rising edge the block SHALL clear all counters and flags, latch pkt_size, and set expected seq=0 and beat=0.
REQ-018 The expected beats per packet SHALL be N = ceil(pkt_size/64).
REQ-019 Expected tkeep SHALL be all-ones on beats 0..N-2.
REQ-020 On beat N-1, the low R bits of expected tkeep SHALL be set, where R = pkt_size mod 64, or 64 when R=0.
REQ-021 Every 32-bit lane of the expected data SHALL be {seq[15:0], beat[15:0]}.
REQ-022 The data compare SHALL cover only bytes whose received tkeep bit is set.
REQ-023 A beat error SHALL be any of: data mismatch, tkeep mismatch, tuser!=0, tlast on beat < N-1 (early), or no tlast on beat N-1 (late).
REQ-024 The packet error flag SHALL be sticky from the first erroneous beat until the packet ends.
REQ-025 A packet ends on an accepted tlast beat; in DRAIN, beats up to and including tlast SHALL belong to the same packet.
REQ-026 At packet end, recv_pkt_cnt+1 SHALL apply always, and err_pkt_cnt+1 SHALL apply when the packet error flag is set (counted once per packet).
REQ-027 At packet end, seq+1 (modulo 2^16) SHALL apply, beat SHALL reset to 0, and the error flag SHALL clear.
REQ-028 total_beat_cnt SHALL increment on each accepted beat while enabled, wrapping modulo 2^32.
REQ-029 first_pkt_seen SHALL set on the first accepted beat after enable.
REQ-030 perf_cycle_cnt SHALL increment every cycle while first_pkt_seen=1 and perf_cycle_full=0.
REQ-031 perf_beat_cnt SHALL increment on each accepted beat under the same condition as REQ-030.
REQ-032 When perf_cycle_cnt reaches 0xFFFF_FFFF it SHALL hold, perf_cycle_full SHALL set, and perf_beat_cnt SHALL freeze.
REQ-033 All outputs SHALL be registered; each count SHALL be visible one cycle after the causing beat.
REQ-034 If the enable rising edge coincides with an accepted beat, the counters SHALL clear and that beat SHALL be discarded.
REQ-035 Disable mid-packet SHALL abandon the packet without incrementing counters; counters SHALL hold their values until the next enable.

Reset
REQ-036 On RST_N=0: all counters 0, flags 0, tready 0, FSM IDLE, seq 0, beat 0, latched size 0.
REQ-037 Reset SHALL be asserted asynchronously and released synchronously into the first CLK edge.

Structure
REQ-038 A shared package axis_perf_pkg SHALL hold DATA_WIDTH/KEEP_WIDTH defaults, the 32-bit lane pattern format and the FSM state encoding; a packet generator SHALL reuse the same pattern definition.
REQ-039 A combinational sub-module axis_rx_expect_gen SHALL take (seq, beat, N, R) and return (expected data, expected tkeep, is_last_beat).

Verification
REQ-040 Scenario: pkt_size=256, 10 clean packets back-to-back -> recv_pkt_cnt=10, err_pkt_cnt=0, total_beat_cnt=40.
REQ-041 Scenario: pkt_size=100, lane 3 of beat 1 of packet 2 corrupted -> err_pkt_cnt=1, recv_pkt_cnt=5 of 5; last-beat tkeep expected 0x0000_000F_FFFF_FFFF.
REQ-042 Scenario: pkt_size=128 with tlast missing on beat 1, tlast on beat 3 -> one packet counted, err_pkt_cnt=1, next packet checked with seq=1.
REQ-043 Scenario: tlast on beat 0 of a 192-byte packet -> err_pkt_cnt=1, beat index restarts at 0.
REQ-044 Scenario: preload perf_cycle_cnt near 0xFFFF_FFFE (force) with continuous traffic -> holds at 0xFFFF_FFFF, perf_cycle_full=1, perf_beat_cnt frozen.
REQ-045 Scenario: enable dropped mid-packet, then re-raised, RST_N pulsed asynchronously mid-beat -> counters clear, tready=0 during reset, seq restarts at 0.

Source files
------------

// File: rtl/axis_perf_pkg.sv
// Definitions shared by the RX checker and the packet generator: bus width
// defaults, the 32-bit lane pattern and the checker FSM encoding.
package axis_perf_pkg;

  localparam int DEF_DATA_WIDTH = 512;
  localparam int DEF_KEEP_WIDTH = DEF_DATA_WIDTH / 8;
  localparam int LANE_WIDTH     = 32;

  typedef struct packed {
    logic [15:0] seq;
    logic [15:0] beat;
  } lane_pat_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_DRAIN = 2'd2
  } rx_state_e;

  function automatic lane_pat_t lane_pattern(input logic [15:0] seq, input logic [15:0] beat);
    lane_pat_t p;
    p.seq  = seq;
    p.beat = beat;
    return p;
  endfunction

endpackage

// File: rtl/axis_rx_expect_gen.sv
// Expected beat contents for a given packet sequence number and beat index.
module axis_rx_expect_gen
  import axis_perf_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int KEEP_WIDTH = DEF_KEEP_WIDTH
) (
  input  logic [15:0]           seq_i,
  input  logic [15:0]           beat_i,
  input  logic [15:0]           n_beats_i,
  input  logic [15:0]           rem_i,
  output logic [DATA_WIDTH-1:0] exp_data_o,
  output logic [KEEP_WIDTH-1:0] exp_keep_o,
  output logic                  is_last_o
);

  localparam int LANES = DATA_WIDTH / LANE_WIDTH;

  always_comb begin
    exp_data_o = '0;
    for (int l = 0; l < LANES; l++) begin
      exp_data_o[l*LANE_WIDTH +: LANE_WIDTH] = lane_pattern(seq_i, beat_i);
    end
    is_last_o  = (beat_i == n_beats_i - 16'd1);
    // rem_i == KEEP_WIDTH shifts everything out, giving a full mask
    exp_keep_o = is_last_o ? ~({KEEP_WIDTH{1'b1}} << rem_i) : {KEEP_WIDTH{1'b1}};
  end

endmodule

// File: rtl/axis_rx_pkt_checker.sv
// AXIS receive-side packet checker: validates the seq/beat lane pattern,
// tkeep and framing of each packet and keeps throughput statistics.
module axis_rx_pkt_checker
  import axis_perf_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int KEEP_WIDTH = DEF_KEEP_WIDTH,
  parameter int USER_WIDTH = 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  input  logic                  enable,
  input  logic [15:0]           pkt_size,
  output logic [31:0]           recv_pkt_cnt,
  output logic [31:0]           err_pkt_cnt,
  output logic [31:0]           total_beat_cnt,
  output logic [31:0]           perf_beat_cnt,
  output logic [31:0]           perf_cycle_cnt,
  output logic                  first_pkt_seen,
  output logic                  perf_cycle_full
);

  localparam int KEEP_LOG2 = $clog2(KEEP_WIDTH);

  rx_state_e   state_q;
  logic        en_q, tready_q, err_q, first_q, full_q;
  logic [15:0] size_q, seq_q, beat_q;
  logic [31:0] recv_q, errcnt_q, total_q, perf_beat_q, perf_cycle_q;

  logic [16:0]           size_round;
  logic [15:0]           n_beats, rem_raw, rem;
  logic [DATA_WIDTH-1:0] exp_data;
  logic [KEEP_WIDTH-1:0] exp_keep;
  logic                  is_last, acc, en_rise, data_bad, beat_err, pkt_end, pkt_bad;

  assign size_round = {1'b0, size_q} + 17'(KEEP_WIDTH - 1);
  assign n_beats    = 16'(size_round >> KEEP_LOG2);
  assign rem_raw    = size_q & 16'(KEEP_WIDTH - 1);
  assign rem        = (rem_raw == 16'd0) ? 16'(KEEP_WIDTH) : rem_raw;

  axis_rx_expect_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .KEEP_WIDTH (KEEP_WIDTH)
  ) u_gen (
    .seq_i      (seq_q),
    .beat_i     (beat_q),
    .n_beats_i  (n_beats),
    .rem_i      (rem),
    .exp_data_o (exp_data),
    .exp_keep_o (exp_keep),
    .is_last_o  (is_last)
  );

  // Bytes the source marked invalid carry no meaning and are not compared
  always_comb begin
    data_bad = 1'b0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      if (s_axis_tkeep[i] && (s_axis_tdata[8*i +: 8] != exp_data[8*i +: 8])) data_bad = 1'b1;
    end
  end

  assign acc      = s_axis_tvalid && tready_q;
  assign en_rise  = enable && !en_q;
  assign beat_err = data_bad || (s_axis_tkeep != exp_keep) || (|s_axis_tuser) ||
                    (s_axis_tlast != is_last);
  assign pkt_end  = s_axis_tlast && ((state_q == ST_RECV) || (state_q == ST_DRAIN));
  assign pkt_bad  = err_q || ((state_q == ST_RECV) && beat_err);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      en_q         <= 1'b0;
      tready_q     <= 1'b0;
      size_q       <= '0;
      seq_q        <= '0;
      beat_q       <= '0;
      err_q        <= 1'b0;
      recv_q       <= '0;
      errcnt_q     <= '0;
      total_q      <= '0;
      perf_beat_q  <= '0;
      perf_cycle_q <= '0;
      first_q      <= 1'b0;
      full_q       <= 1'b0;
    end else begin
      tready_q <= 1'b1;
      en_q     <= enable;
      if (!enable) begin
        state_q <= ST_IDLE;
      end else if (en_rise) begin
        state_q      <= ST_RECV;
        size_q       <= pkt_size;
        seq_q        <= '0;
        beat_q       <= '0;
        err_q        <= 1'b0;
        recv_q       <= '0;
        errcnt_q     <= '0;
        total_q      <= '0;
        perf_beat_q  <= '0;
        perf_cycle_q <= '0;
        first_q      <= 1'b0;
        full_q       <= 1'b0;
      end else begin
        if (first_q && !full_q) begin
          if (perf_cycle_q >= 32'hFFFF_FFFE) begin
            perf_cycle_q <= '1;
            full_q       <= 1'b1;
          end else begin
            perf_cycle_q <= perf_cycle_q + 32'd1;
          end
          if (acc) perf_beat_q <= perf_beat_q + 32'd1;
        end
        if (acc) begin
          total_q <= total_q + 32'd1;
          first_q <= 1'b1;
          if (pkt_end) begin
            recv_q  <= recv_q + 32'd1;
            if (pkt_bad) errcnt_q <= errcnt_q + 32'd1;
            seq_q   <= seq_q + 16'd1;
            beat_q  <= '0;
            err_q   <= 1'b0;
            state_q <= ST_RECV;
          end else if (state_q == ST_RECV) begin
            // Missing tlast on the final beat: swallow the rest up to tlast
            if (is_last) begin
              state_q <= ST_DRAIN;
              err_q   <= 1'b1;
            end else begin
              beat_q <= beat_q + 16'd1;
              err_q  <= err_q || beat_err;
            end
          end
        end
      end
    end
  end

  assign s_axis_tready   = tready_q;
  assign recv_pkt_cnt    = recv_q;
  assign err_pkt_cnt     = errcnt_q;
  assign total_beat_cnt  = total_q;
  assign perf_beat_cnt   = perf_beat_q;
  assign perf_cycle_cnt  = perf_cycle_q;
  assign first_pkt_seen  = first_q;
  assign perf_cycle_full = full_q;

endmodule

// File: tb/tb_axis_rx_pkt_checker.sv
// Directed bench for axis_rx_pkt_checker with hand-computed expected counts.
module tb_axis_rx_pkt_checker;
  import axis_perf_pkg::*;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         tvalid = 1'b0, tlast = 1'b0, enable = 1'b0;
  logic         tready;
  logic [511:0] tdata = '0;
  logic [63:0]  tkeep = '0;
  logic [0:0]   tuser = '0;
  logic [15:0]  pkt_size = '0;
  logic [31:0]  recv_cnt, err_cnt, total_cnt, pbeat_cnt, pcycle_cnt;
  logic         first_seen, pfull;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  axis_rx_pkt_checker dut (
    .CLK             (CLK),
    .RST_N           (RST_N),
    .s_axis_tvalid   (tvalid),
    .s_axis_tready   (tready),
    .s_axis_tlast    (tlast),
    .s_axis_tdata    (tdata),
    .s_axis_tkeep    (tkeep),
    .s_axis_tuser    (tuser),
    .enable          (enable),
    .pkt_size        (pkt_size),
    .recv_pkt_cnt    (recv_cnt),
    .err_pkt_cnt     (err_cnt),
    .total_beat_cnt  (total_cnt),
    .perf_beat_cnt   (pbeat_cnt),
    .perf_cycle_cnt  (pcycle_cnt),
    .first_pkt_seen  (first_seen),
    .perf_cycle_full (pfull)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] last_keep(input int size);
    int r;
    r = size % 64;
    if (r == 0) return '1;
    return (64'd1 << r) - 64'd1;
  endfunction

  task automatic beat(input int sq, input int bt, input logic [63:0] kp, input logic lst,
                      input int bad_lane, input logic usr);
    lane_pat_t   lp;
    logic [31:0] lane;
    @(negedge CLK);
    lp.seq  = 16'(sq);
    lp.beat = 16'(bt);
    lane    = lp;
    for (int l = 0; l < 16; l++) tdata[32*l +: 32] = (l == bad_lane) ? (lane ^ 32'h0000_0100) : lane;
    for (int b = 0; b < 64; b++) if (!kp[b]) tdata[8*b +: 8] = 8'hAA;
    tkeep  = kp;
    tlast  = lst;
    tuser  = usr;
    tvalid = 1'b1;
  endtask

  task automatic send_pkt(input int sq, input int size, input int bad_beat, input int bad_lane);
    int n;
    n = (size + 63) / 64;
    for (int b = 0; b < n; b++)
      beat(sq, b, (b == n - 1) ? last_keep(size) : '1, (b == n - 1),
           (b == bad_beat) ? bad_lane : -1, 1'b0);
  endtask

  task automatic stop();
    @(negedge CLK);
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic restart(input int size);
    @(negedge CLK);
    enable = 1'b0;
    tvalid = 1'b0;
    @(negedge CLK);
    pkt_size = 16'(size);
    enable   = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("rst_tready", 32'(tready), 32'd0);
    check("rst_recv", recv_cnt, 32'd0);
    check("rst_total", total_cnt, 32'd0);
    check("rst_first", 32'(first_seen), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check("tready_up", 32'(tready), 32'd1);

    // Ten clean 256-byte packets back-to-back
    restart(256);
    for (int s = 0; s < 10; s++) send_pkt(s, 256, -1, -1);
    stop();
    check("s1_recv", recv_cnt, 32'd10);
    check("s1_err", err_cnt, 32'd0);
    check("s1_total", total_cnt, 32'd40);
    check("s1_first", 32'(first_seen), 32'd1);
    check("s1_pbeat", pbeat_cnt, 32'd39);
    check("s1_pcycle", pcycle_cnt, 32'd39);

    // Disable holds counters; enable edge with a coincident beat clears and drops it
    @(negedge CLK);
    enable = 1'b0;
    @(negedge CLK);
    check("hold_recv", recv_cnt, 32'd10);
    check("hold_total", total_cnt, 32'd40);
    pkt_size = 16'd100;
    enable   = 1'b1;
    tvalid   = 1'b1;
    tlast    = 1'b1;
    tkeep    = '1;
    @(negedge CLK);
    check("rise_recv", recv_cnt, 32'd0);
    check("rise_total", total_cnt, 32'd0);
    tvalid = 1'b0;

    // 100-byte packets, lane 3 of beat 1 of packet 2 corrupted
    beat(0, 0, '1, 1'b0, -1, 1'b0);
    beat(0, 1, last_keep(100), 1'b1, -1, 1'b0);
    #1;
    check("keep100_hi", dut.exp_keep[63:32], 32'h0000_000F);
    check("keep100_lo", dut.exp_keep[31:0], 32'hFFFF_FFFF);
    for (int s = 1; s < 5; s++) send_pkt(s, 100, (s == 2) ? 1 : -1, 3);
    stop();
    check("s2_recv", recv_cnt, 32'd5);
    check("s2_err", err_cnt, 32'd1);
    check("s2_total", total_cnt, 32'd10);
    // tuser set on beat 0, then a last beat with a full tkeep
    beat(5, 0, '1, 1'b0, -1, 1'b1);
    beat(5, 1, last_keep(100), 1'b1, -1, 1'b0);
    beat(6, 0, '1, 1'b0, -1, 1'b0);
    beat(6, 1, '1, 1'b1, -1, 1'b0);
    stop();
    check("s2b_recv", recv_cnt, 32'd7);
    check("s2b_err", err_cnt, 32'd3);
    check("s2b_total", total_cnt, 32'd14);

    // Late tlast on a 128-byte packet
    restart(128);
    beat(0, 0, '1, 1'b0, -1, 1'b0);
    beat(0, 1, '1, 1'b0, -1, 1'b0);
    beat(0, 2, '1, 1'b0, -1, 1'b0);
    beat(0, 3, '1, 1'b1, -1, 1'b0);
    send_pkt(1, 128, -1, -1);
    stop();
    check("late_recv", recv_cnt, 32'd2);
    check("late_err", err_cnt, 32'd1);
    check("late_total", total_cnt, 32'd6);

    // Early tlast on beat 0 of a 192-byte packet
    restart(192);
    beat(0, 0, '1, 1'b1, -1, 1'b0);
    send_pkt(1, 192, -1, -1);
    stop();
    check("early_recv", recv_cnt, 32'd2);
    check("early_err", err_cnt, 32'd1);
    check("early_total", total_cnt, 32'd4);

    // Perf cycle counter saturation under continuous traffic
    restart(64);
    for (int i = 0; i < 10; i++) begin
      beat(i, 0, '1, 1'b1, -1, 1'b0);
      if (i == 3) force dut.perf_cycle_q = 32'hFFFF_FFFD;
      if (i == 4) release dut.perf_cycle_q;
    end
    stop();
    check("sat_pcycle", pcycle_cnt, 32'hFFFF_FFFF);
    check("sat_full", 32'(pfull), 32'd1);
    check("sat_pbeat", pbeat_cnt, 32'd5);
    check("sat_total", total_cnt, 32'd10);
    check("sat_recv", recv_cnt, 32'd10);

    // Disable mid-packet, beats while disabled, re-enable
    restart(128);
    beat(0, 0, '1, 1'b0, -1, 1'b0);
    @(negedge CLK);
    enable = 1'b0;
    tvalid = 1'b0;
    beat(0, 1, '1, 1'b1, -1, 1'b0);
    stop();
    check("abandon_total", total_cnt, 32'd1);
    check("abandon_recv", recv_cnt, 32'd0);
    restart(128);
    send_pkt(0, 128, -1, -1);
    stop();
    check("reen_recv", recv_cnt, 32'd1);
    check("reen_err", err_cnt, 32'd0);

    // Asynchronous reset in the middle of a beat
    beat(1, 0, '1, 1'b0, -1, 1'b0);
    #2;
    RST_N = 1'b0;
    #1;
    check("arst_tready", 32'(tready), 32'd0);
    check("arst_recv", recv_cnt, 32'd0);
    check("arst_total", total_cnt, 32'd0);
    check("arst_first", 32'(first_seen), 32'd0);
    @(negedge CLK);
    check("arst_tready_hold", 32'(tready), 32'd0);
    tvalid = 1'b0;
    RST_N  = 1'b1;
    send_pkt(0, 128, -1, -1);
    stop();
    check("post_rst_recv", recv_cnt, 32'd1);
    check("post_rst_err", err_cnt, 32'd0);
    check("post_rst_total", total_cnt, 32'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
